// File: rtl/shift_load_timer_if.sv
// Control/status bundle of the shift-load timer: load-sequence controls in,
// phase progress and completion status out.
interface shift_load_timer_if #(
    parameter int unsigned CNT_W = 5
);
    logic             start;
    logic             skip_mid;
    logic             shift_valid;
    logic             abort;
    logic             done_ack;
    logic             midstate_shifts_done;
    logic             remaining_shifts_done;
    logic             done;
    logic             busy;
    logic [1:0]       phase;
    logic [CNT_W-1:0] shift_count;
    logic             stray_err;

    modport master (
        output start, skip_mid, shift_valid, abort, done_ack,
        input  midstate_shifts_done, remaining_shifts_done, done, busy,
               phase, shift_count, stray_err
    );

    modport slave (
        input  start, skip_mid, shift_valid, abort, done_ack,
        output midstate_shifts_done, remaining_shifts_done, done, busy,
               phase, shift_count, stray_err
    );
endinterface

// File: rtl/shift_load_timer.sv
// Counts accepted shifts through the midstate and remaining-data phases of a
// load sequence and flags completion; every output comes straight from a flop.
module shift_load_timer #(
    parameter int unsigned MID_LEN = 8,
    parameter int unsigned REM_LEN = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 n_rst,
    shift_load_timer_if.slave    bus
);
    localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

    if (MID_LEN == 0 || MID_LEN > CNT_MAX) begin : g_bad_mid_len
        $error("shift_load_timer: MID_LEN must be in 1..2^CNT_W-1");
    end
    if (REM_LEN == 0 || REM_LEN > CNT_MAX) begin : g_bad_rem_len
        $error("shift_load_timer: REM_LEN must be in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(MID_LEN - 1);
    localparam logic [CNT_W-1:0] REM_LAST = CNT_W'(REM_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // State encoding doubles as the phase output code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MID  = 2'b01,
        ST_REM  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stray_q, stray_d;
    logic             mid_pulse_q, mid_pulse_d;
    logic             rem_pulse_q, rem_pulse_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Next-state, counter, sticky stray flag and completion pulse decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stray_d     = stray_q;
        mid_pulse_d = 1'b0;
        rem_pulse_d = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = bus.skip_mid ? ST_REM : ST_MID;
                        cnt_d   = '0;
                        stray_d = 1'b0;
                    end else if (bus.shift_valid) begin
                        stray_d = 1'b1;
                    end else begin
                        stray_d = stray_q;
                    end
                end
                ST_MID: begin
                    if (bus.shift_valid && (cnt_q == MID_LAST)) begin
                        state_d     = ST_REM;
                        cnt_d       = '0;
                        mid_pulse_d = 1'b1;
                    end else if (bus.shift_valid) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_REM: begin
                    if (bus.shift_valid && (cnt_q == REM_LAST)) begin
                        state_d     = ST_DONE;
                        cnt_d       = '0;
                        rem_pulse_d = 1'b1;
                    end else if (bus.shift_valid) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DONE: begin
                    // A shift arriving after completion is a stray word.
                    if (bus.shift_valid) begin
                        stray_d = 1'b1;
                    end else begin
                        stray_d = stray_q;
                    end
                    if (bus.done_ack) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_MID) || (state_d == ST_REM);
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stray_q     <= 1'b0;
            mid_pulse_q <= 1'b0;
            rem_pulse_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stray_q     <= stray_d;
            mid_pulse_q <= mid_pulse_d;
            rem_pulse_q <= rem_pulse_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.midstate_shifts_done  = mid_pulse_q;
    assign bus.remaining_shifts_done = rem_pulse_q;
    assign bus.done                  = done_q;
    assign bus.busy                  = busy_q;
    assign bus.phase                 = state_q;
    assign bus.shift_count           = cnt_q;
    assign bus.stray_err             = stray_q;

endmodule
